slow_mem_responder: RTL and testbench
=====================================

// Module: slow_mem_responder
// PURPOSE
//  Responder end of the cache<->slow-memory line interface, used by both cache_i and cache_d.
//  Accepts one 128-bit line read or write per request and answers after a programmable latency
//  with a single-cycle mem_ready pulse. Backs the I and D caches in simulation and FPGA
//  bring-up; one instance per cache port.
// PARAMETERS
//  LATENCY     4    cycles from request accept to mem_ready (>=1)
//  IDX_W       10   line-index bits; storage depth = 2**IDX_W lines of 128 bits
// PORTS
//  clk         in   1    rising-edge clock
//  rst_n       in   1    asynchronous active-low reset
//  mem_read    in   1    line read request, held by cache until mem_ready
//  mem_write   in   1    line write request, held by cache until mem_ready
//  mem_addr    in   28   line address [31:4]; held stable with request
//  mem_wdata   in   128  write line data; valid with mem_write
//  mem_rdata   out  128  read line data; valid only while mem_ready=1
//  mem_ready   out  1    one-cycle completion pulse
//  proto_err   out  1    sticky: read+write both high at accept
// BEHAVIOUR
//  Reset: state=IDLE, mem_ready=0, mem_rdata=0, proto_err=0, counter=0. Array not cleared.
//  States: IDLE -> WAIT -> RESP -> RECOVER -> IDLE.
//  IDLE: at edge T0 with (mem_read|mem_write): latch op, index=mem_addr[IDX_W+3:4],
//   wdata; cnt=LATENCY-1; go WAIT. No request: stay IDLE.
//  WAIT: cnt decrements each edge; at cnt==0 edge go RESP. Input changes ignored (latched).
//  RESP: mem_ready=1 exactly during cycle [T0+LATENCY, T0+LATENCY+1). Read: mem_rdata =
//   array[index] (registered, same cycle as ready). Write: array[index]<=wdata on the
//   RESP-entry edge; mem_rdata stays 0. Next edge go RECOVER.
//  RECOVER: 1 cycle, ready=0, requests ignored (cache drops request after seeing ready).
//  Back-to-back: earliest next accept edge = T0+LATENCY+2.
//  LATENCY=1: WAIT skipped; IDLE -> RESP directly.
//  Both read and write at accept: write wins, proto_err set and held until reset.
//  Upper address bits above IDX_W+3 ignored: addresses alias (wrap) modulo depth.
//  Request dropped by cache during WAIT: transaction still completes (latched); write lands.
//  Reset mid-transaction: abort immediately, outputs to reset values; pending write that
//   has not reached RESP-entry edge is discarded.
//  mem_rdata returns to 0 when leaving RESP.
// STRUCTURE
//  Package slow_mem_pkg: LINE_W=128, ADDR_W=28, state enum {IDLE,WAIT,RESP,RECOVER}.
//  Sub-module slow_mem_array: 2**IDX_W x 128 synchronous-write/registered-read store.
//  Top holds FSM, latency counter, request latch, proto_err.
// TESTING
//  1 Write addr 0x0000010, data 0xA5..A5, LATENCY=4 -> ready 1 cycle at T0+4; read back
//    same addr -> ready at T1+4 with rdata 0xA5..A5.
//  2 Back-to-back reads held continuously -> second accept at T0+LATENCY+2, never earlier.
//  3 Read+write both high at accept -> write performed, proto_err=1 and sticky.
//  4 Write addr 0x0000400 (IDX_W=10) then read addr 0x0000000 -> aliased data returned.
//  5 rst_n low in WAIT of a write -> ready=0 at once, later read shows old data.
//  6 LATENCY=1: request at T0 -> ready during cycle after T0 edge, RECOVER next.

Source files
------------

// File: rtl/slow_mem_pkg.sv
// Shared types and widths for the cache <-> slow-memory line responder.
package slow_mem_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    RECOVER
  } state_t;

  // Width of the latency down-counter; at least one bit even when the wait phase is skipped.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/slow_mem_array.sv
// Line store: synchronous write, registered read, no reset so it maps onto block RAM.
module slow_mem_array
  import slow_mem_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [LINE_W-1:0] mem [DEPTH];

  // Single-port access: write or registered read at the addressed line.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/slow_mem_responder.sv
// Responder end of the cache line interface: latches one line request, waits LATENCY
// cycles, then answers with a one-cycle mem_ready pulse (read data valid alongside).
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err
);

  localparam int CNT_W = cnt_width(LATENCY);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              op_write_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic              proto_err_reg;

  logic              accept;
  logic              enter_resp;
  logic              use_live;
  logic [IDX_W-1:0]  arr_addr;
  logic [LINE_W-1:0] arr_wdata;
  logic              arr_write;
  logic              arr_we;
  logic              arr_re;
  logic [LINE_W-1:0] arr_rdata;

  // mem_addr is already a line address, so its low IDX_W bits select the line and the
  // rest alias; fold the ignored bits into a deliberately unused net.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[ADDR_W-1:IDX_W];

  assign accept = (state_reg == IDLE) && (mem_read || mem_write);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: RESP is entered on the edge that makes mem_ready visible to the cache
  // on the LATENCY-th edge after accept; LATENCY=1 goes straight from IDLE to RESP.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_reg == CNT_W'(1)) state_next = RESP;
      RESP:    state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch and latency counter; counter hits 0 on the edge that enters RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      op_write_reg <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
    end else if (accept) begin
      cnt_reg      <= CNT_W'(LATENCY - 1);
      op_write_reg <= mem_write;
      idx_reg      <= mem_addr[IDX_W-1:0];
      wdata_reg    <= mem_wdata;
    end else if (state_reg == WAIT) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Sticky protocol error: read and write both asserted at accept (write still wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_reg <= 1'b0;
    end else if (accept && mem_read && mem_write) begin
      proto_err_reg <= 1'b1;
    end
  end

  // Array access on the RESP-entry edge; when that edge is the accept edge itself
  // (LATENCY=1) the live request is used instead of the not-yet-latched copy.
  always_comb begin
    enter_resp = (state_next == RESP) && (state_reg != RESP);
    use_live   = (state_reg == IDLE);
    arr_addr   = use_live ? mem_addr[IDX_W-1:0] : idx_reg;
    arr_wdata  = use_live ? mem_wdata : wdata_reg;
    arr_write  = use_live ? mem_write : op_write_reg;
    arr_we     = enter_resp && arr_write && rst_n;
    arr_re     = enter_resp && !arr_write && rst_n;
  end

  slow_mem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Outputs: ready only in RESP, read data gated so it is zero outside a read response.
  always_comb begin
    mem_ready = (state_reg == RESP);
    mem_rdata = ((state_reg == RESP) && !op_write_reg) ? arr_rdata : '0;
    proto_err = proto_err_reg;
  end

endmodule

// File: tb/tb_slow_mem_responder.sv
// Bench for slow_mem_responder: LATENCY=4/IDX_W=10 and LATENCY=1/IDX_W=4 instances
// checked against a line-indexed memory model and latency arithmetic.
module tb_slow_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         r0, w0, r1, w1;
  logic [27:0]  a0, a1;
  logic [127:0] d0, d1;
  logic [127:0] q0, q1;
  logic         rdy0, rdy1, pe0, pe1;

  int checks = 0;
  int errors = 0;

  logic [127:0] mem0 [int];
  logic [127:0] mem1 [int];
  bit           pe_exp0, pe_exp1;

  always #5 clk = ~clk;

  slow_mem_responder #(.LATENCY(4), .IDX_W(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(r0), .mem_write(w0), .mem_addr(a0),
    .mem_wdata(d0), .mem_rdata(q0), .mem_ready(rdy0), .proto_err(pe0)
  );

  slow_mem_responder #(.LATENCY(1), .IDX_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(r1), .mem_write(w1), .mem_addr(a1),
    .mem_wdata(d1), .mem_rdata(q1), .mem_ready(rdy1), .proto_err(pe1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input bit rd, input bit wr,
                       input logic [27:0] addr, input logic [127:0] data);
    if (inst == 0) begin r0 = rd; w0 = wr; a0 = addr; d0 = data; end
    else           begin r1 = rd; w1 = wr; a1 = addr; d1 = data; end
  endtask

  function automatic int line_idx(input int inst, input logic [27:0] addr);
    return (inst == 0) ? int'(addr[9:0]) : int'(addr[3:0]);
  endfunction

  function automatic bit model_has(input int inst, input int idx);
    return (inst == 0) ? mem0.exists(idx) : mem1.exists(idx);
  endfunction

  function automatic logic [127:0] model_rd(input int inst, input int idx);
    if (!model_has(inst, idx)) return '0;
    return (inst == 0) ? mem0[idx] : mem1[idx];
  endfunction

  // One cache transaction, starting and ending on a negedge with the responder idle.
  task automatic txn(input int inst, input bit rd, input bit wr,
                     input logic [27:0] addr, input logic [127:0] data, input bit drop);
    int lat, lexp, idx;
    bit known;
    logic [127:0] exp_rd, obs_rd;
    lexp   = (inst == 0) ? 4 : 1;
    idx    = line_idx(inst, addr);
    known  = 1'b1;
    exp_rd = '0;
    if (rd && !wr) begin
      known  = model_has(inst, idx);
      exp_rd = model_rd(inst, idx);
    end
    drive(inst, rd, wr, addr, data);
    lat = 0;
    obs_rd = '0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if ((inst == 0) ? rdy0 : rdy1) begin
        lat = i;
        obs_rd = (inst == 0) ? q0 : q1;
        break;
      end
      if (drop && i == 1) drive(inst, 1'b0, 1'b0, ~addr, ~data);
    end
    check("latency", lat, lexp);
    if (known) check("rdata", obs_rd, exp_rd);
    if (wr) begin
      if (inst == 0) mem0[idx] = data; else mem1[idx] = data;
    end
    if (rd && wr) begin
      if (inst == 0) pe_exp0 = 1'b1; else pe_exp1 = 1'b1;
    end
    check("proto_err", (inst == 0) ? pe0 : pe1, (inst == 0) ? pe_exp0 : pe_exp1);
    $display("txn inst=%0d rd=%0d wr=%0d drop=%0d addr=%h lat=%0d rdata=%h",
             inst, rd, wr, drop, addr, lat, obs_rd);
    drive(inst, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("recover_ready", (inst == 0) ? rdy0 : rdy1, 1'b0);
    check("recover_rdata", (inst == 0) ? q0 : q1, '0);
    @(negedge clk);
  endtask

  // Read held continuously across two responses: gap between ready pulses is LATENCY+2.
  task automatic b2b(input int inst, input logic [27:0] addr);
    int lexp, first, gap, idx;
    bit known;
    logic [127:0] exp_rd;
    lexp   = (inst == 0) ? 4 : 1;
    idx    = line_idx(inst, addr);
    known  = model_has(inst, idx);
    exp_rd = model_rd(inst, idx);
    drive(inst, 1'b1, 1'b0, addr, '0);
    first = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if ((inst == 0) ? rdy0 : rdy1) begin first = i; break; end
    end
    check("b2b_first_latency", first, lexp);
    if (known) check("b2b_first_rdata", (inst == 0) ? q0 : q1, exp_rd);
    gap = 0;
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      if ((inst == 0) ? rdy0 : rdy1) begin gap = j; break; end
    end
    check("b2b_gap", gap, lexp + 2);
    if (known) check("b2b_second_rdata", (inst == 0) ? q0 : q1, exp_rd);
    $display("b2b inst=%0d addr=%h first=%0d gap=%0d", inst, addr, first, gap);
    drive(inst, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] rnd;
    logic [27:0]  ra;
    int           inst, op;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    pe_exp0 = 1'b0;
    pe_exp1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready0", rdy0, 1'b0);
    check("reset_rdata0", q0, '0);
    check("reset_proto0", pe0, 1'b0);
    check("reset_ready1", rdy1, 1'b0);
    check("reset_proto1", pe1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back.
    txn(0, 1'b0, 1'b1, 28'h0000010, {16{8'hA5}}, 1'b0);
    txn(0, 1'b1, 1'b0, 28'h0000010, '0, 1'b0);

    // Aliasing: 0x400 wraps onto line 0.
    txn(0, 1'b0, 1'b1, 28'h0000400, {4{32'h1234_5678}}, 1'b0);
    txn(0, 1'b1, 1'b0, 28'h0000000, '0, 1'b0);

    // Request dropped during WAIT: write still lands at the latched address.
    txn(0, 1'b0, 1'b1, 28'h0000020, {4{32'hCAFE_F00D}}, 1'b1);
    txn(0, 1'b1, 1'b0, 28'h0000020, '0, 1'b0);

    // Back-to-back held reads.
    b2b(0, 28'h0000010);

    // Read+write together: write wins, proto_err sticky.
    txn(0, 1'b1, 1'b1, 28'h0000030, {4{32'hDEAD_BEEF}}, 1'b0);
    txn(0, 1'b1, 1'b0, 28'h0000030, '0, 1'b0);

    // Reset during WAIT of a write: aborted, old data survives.
    drive(0, 1'b0, 1'b1, 28'h0000030, {4{32'h0BAD_0BAD}});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ready", rdy0, 1'b0);
    check("midreset_rdata", q0, '0);
    check("midreset_proto", pe0, 1'b0);
    pe_exp0 = 1'b0;
    pe_exp1 = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 1'b1, 1'b0, 28'h0000030, '0, 1'b0);

    // LATENCY=1 instance.
    txn(1, 1'b0, 1'b1, 28'h0000005, {8{16'h5A5A}}, 1'b0);
    txn(1, 1'b1, 1'b0, 28'h0000005, '0, 1'b0);
    b2b(1, 28'h0000005);

    // Randomized mix on both instances; upper address bits random to exercise aliasing.
    for (int n = 0; n < 60; n++) begin
      inst = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 9));
      ra   = {18'($urandom()), 6'd0, 4'($urandom_range(0, 15))};
      rnd  = {$urandom(), $urandom(), $urandom(), $urandom()};
      txn(inst, (op == 0) || (op >= 5), (op <= 4), ra, rnd,
          (inst == 0) && ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
